spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- SPI mode-0 target (responder) clocked entirely by the system clock; it is the far-end counterpart of the team's SPI master.
- sclk, cs and mosi are oversampled through synchronizers. Receive bytes are presented on a valid/ready interface; transmit bytes are taken from a one-entry holding buffer.
- The block is used as an on-chip loopback target for master verification, and as the core of future SPI-attached peripheral register files.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; MSB first.
- SYNC_STAGES, 2, flip-flop depth of the sclk/cs/mosi synchronizers (minimum 2).
- DEFAULT_TX, {DATA_WIDTH{1'b1}}, word shifted out when the tx buffer is empty at a word boundary.

Ports:
- ACLK  in  1  system clock; all logic on posedge.
- ARESETN  in  1  synchronous active-low reset.
- sclk  in  1  SPI clock from master; asynchronous to ACLK.
- cs  in  1  chip select, active low; asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- miso_oe  out  1  miso output enable; 1 while a frame is active.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty; handshake completes when tx_valid && tx_ready.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  rx_data valid; held until accepted.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  frame active (state ACTIVE).
- frame_done  out  1  1-cycle pulse: cs deasserted on a word boundary.
- frame_abort  out  1  1-cycle pulse: cs deasserted mid-word.
- tx_underrun  out  1  1-cycle pulse: DEFAULT_TX loaded because the buffer was empty.
- rx_overrun  out  1  1-cycle pulse: a word completed while rx_valid=1 and rx_ready=0.

Behaviour:
- **Reset values:** miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, all pulses 0. State=IDLE, bit_cnt=0, shift registers 0, synchronizers 0, cs history=1.
- **Synchronization:** sclk, cs and mosi each pass through SYNC_STAGES flops. An edge is detected by comparing the synchronized value with a one-cycle-delayed copy. An action occurs on the ACLK edge after detection, so pin-to-action latency is SYNC_STAGES+1 cycles.
- **Timing requirement:** sclk half-period must be at least SYNC_STAGES+3 ACLK cycles. Behaviour below that is undefined.
- **State IDLE:**
  - miso_oe=0 and sclk edges are ignored.
  - A detected cs falling edge moves to ACTIVE, clears bit_cnt, and loads tx_shift.
  - miso=tx_shift MSB from the same cycle; miso_oe=1.
- **tx load rule:**
  - If the holding buffer is full, load it and empty the buffer (tx_ready=1 the next cycle).
  - Otherwise load DEFAULT_TX and pulse tx_underrun.
  - A tx handshake completing in the same cycle as a load does not feed that load; it fills the buffer for the next word.
- **State ACTIVE, sclk rising edge:**
  - rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - At bit_cnt==DATA_WIDTH-1 the word completes: bit_cnt wraps to 0 and the completed word goes to the rx output rule.
- **State ACTIVE, sclk falling edge:**
  - If bit_cnt==0, a word boundary has passed: perform the tx load rule.
  - Otherwise tx_shift shifts left and miso takes the new MSB.
- **rx output rule:**
  - If rx_valid==0, or rx_ready==1 in the same cycle: rx_data <= word, rx_valid <= 1.
  - Otherwise the new word is dropped, rx_data is kept, and rx_overrun pulses.
  - rx_valid clears on rx_valid && rx_ready when no new word completes that cycle.
- **cs rising edge in ACTIVE:**
  - Return to IDLE; miso_oe=0, miso=0.
  - bit_cnt==0: frame_done pulses.
  - bit_cnt!=0: frame_abort pulses, the partial word is discarded, and bit_cnt is cleared.
  - The tx holding buffer is retained across frames.
- **cs low at reset release:** no frame starts until cs is seen high and then a falling edge is detected.
- **Simultaneous sclk and cs edges:** the cs edge has priority; the sclk edge is ignored.
- **busy:** equals (state==ACTIVE).

Test Plan:
- **Single word:** buffer preloaded with 0x3C; master sends 0xA5 at half-period 8 ACLK.
  - Expected: master reads 0x3C; rx_data=0xA5 with rx_valid=1; one frame_done; no underrun, overrun or abort.
- **Back-to-back words:** tx 0x81, then 0x7E pushed during word 1; master sends 0x12, 0x34 in one frame.
  - Expected: master reads 0x81 then 0x7E; rx yields 0x12 then 0x34 (rx_ready=1); tx_ready rises after each load.
- **Underrun:** empty buffer; master sends 0x00.
  - Expected: master reads 0xFF; tx_underrun pulses exactly once at cs fall.
- **Overrun:** rx_ready held 0; master sends 0x55, 0xAA.
  - Expected: rx_data stays 0x55 with rx_valid=1; rx_overrun pulses once at completion of word 2.
- **Abort:** cs deasserted after 3 sclk rising edges.
  - Expected: no rx_valid; frame_abort pulses once, not frame_done.
  - A following full frame sending 0xC3 is then received correctly.
- **Reset mid-frame:** ARESETN low for 2 cycles during ACTIVE with cs held low.
  - Expected: all outputs at reset values; sclk toggles are ignored until cs goes high then low.
  - A subsequent 0x5A frame is received correctly.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI mode-0 target running entirely on ACLK: sclk/cs/mosi are oversampled,
// rx words leave on a valid/ready port, tx words come from a one-entry buffer.
module spi_slave_core #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = {DATA_WIDTH{1'b1}}
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  tx_underrun,
  output logic                  rx_overrun
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_q, cs_q, cs_armed;
  logic [DATA_WIDTH-1:0]   tx_shift, rx_shift, tx_buf;
  logic                    tx_full;

  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                    do_load, word_done, tx_push;
  logic [DATA_WIDTH-1:0]   load_word, rx_word;

  // Handshakes: a transfer happens on any ACLK edge where valid && ready;
  // valid must hold its data until that edge, ready may change freely.
  assign tx_ready = ~tx_full;
  assign busy     = (state == ACTIVE);

  // cs_armed stays low until cs has been seen high, so a cs held low
  // through reset release cannot start a frame.
  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    cs_s      = cs_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_q;
    sclk_fall = ~sclk_s & sclk_q;
    cs_fall   = ~cs_s & cs_q & cs_armed;
    cs_rise   = cs_s & ~cs_q;
    tx_push   = tx_valid & ~tx_full;
    load_word = tx_full ? tx_buf : DEFAULT_TX;
    rx_word   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    do_load   = ((state == IDLE) && cs_fall) ||
                ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));
    word_done = (state == ACTIVE) && !cs_rise && sclk_rise && (bit_cnt == LAST_BIT);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sclk_sync   <= '0;
      cs_sync     <= '0;
      mosi_sync   <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      cs_armed    <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q      <= sclk_s;
      cs_q        <= cs_s;
      if (cs_s) cs_armed <= 1'b1;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      // A push in the same cycle as a load refills the buffer for the next word.
      if (do_load) begin
        tx_shift <= load_word;
        miso     <= load_word[DATA_WIDTH-1];
        if (tx_full) tx_full <= 1'b0;
        else         tx_underrun <= 1'b1;
      end
      if (tx_push) begin
        tx_full <= 1'b1;
        tx_buf  <= tx_data;
      end

      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            miso_oe  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt == '0) frame_done  <= 1'b1;
            else               frame_abort <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= rx_word;
            bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
          end else if (sclk_fall && (bit_cnt != '0)) begin
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[DATA_WIDTH-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a cycle-timed SPI master plus a word-level model
// of the tx buffer, rx port and status pulses.
module tb_spi_slave_core;
  localparam int W = 8;
  localparam logic [W-1:0] DEF = 8'hFF;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic         tx_valid = 1'b0, rx_ready = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         miso, miso_oe, tx_ready, rx_valid, busy;
  logic         frame_done, frame_abort, tx_underrun, rx_overrun;
  logic [W-1:0] rx_data;

  int n_checks = 0, n_errors = 0;
  int n_done = 0, n_abort = 0, n_under = 0, n_over = 0;
  logic [W-1:0] got_arr[512];
  int           got_n = 0, got_rd = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] buf_q[$];
  logic [W-1:0] mo_w[3], push_w[3];
  bit           push_en[3];
  int           hp = 8;
  bit           held = 1'b0;
  logic [W-1:0] held_word = '0;
  int           exp_under = 0, exp_over = 0;

  always #5 ACLK = ~ACLK;

  spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(2), .DEFAULT_TX(DEF)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_done(frame_done),
    .frame_abort(frame_abort), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
  );

  // Pulse counters and rx capture, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (tx_underrun) n_under++;
    if (rx_overrun)  n_over++;
    if (ARESETN && rx_valid && rx_ready && got_n < 512) begin
      got_arr[got_n] = rx_data;
      got_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic push_tx(input logic [W-1:0] v);
    check("tx_ready_before_push", {31'd0, tx_ready}, 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    buf_q.push_back(v);
  endtask

  task automatic model_load(output logic [W-1:0] w);
    if (buf_q.size() > 0) w = buf_q.pop_front();
    else begin
      w = DEF;
      exp_under++;
    end
  endtask

  task automatic model_rx(input logic [W-1:0] w, input bit rdy);
    if (rdy || !held) begin
      exp_q.push_back(w);
      if (!rdy) begin
        held      = 1'b1;
        held_word = w;
      end
    end else begin
      exp_over++;
    end
  endtask

  task automatic clear_push();
    for (int k = 0; k < 3; k++) push_en[k] = 1'b0;
  endtask

  // One frame: the last sclk fall of the frame coincides with cs rising.
  task automatic run_frame(input int nwords, input int abort_bits, input bit rdy);
    int total, d0, a0, u0, o0;
    logic [W-1:0] exp_tx, got;
    total = (abort_bits > 0) ? abort_bits : nwords * W;
    d0 = n_done; a0 = n_abort; u0 = n_under; o0 = n_over;
    exp_under = 0; exp_over = 0; held = 1'b0;
    rx_ready = rdy;
    got = '0;
    model_load(exp_tx);
    cs = 1'b0;
    for (int i = 0; i < total; i++) begin
      mosi = mo_w[i / W][W - 1 - (i % W)];
      cyc(hp);
      if (i == 0) begin
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        check("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
      end
      got = {got[W-2:0], miso};
      sclk = 1'b1;
      if ((i % W) == 3 && push_en[i / W] && abort_bits == 0 && buf_q.size() == 0) begin
        push_tx(push_w[i / W]);
        cyc(hp - 1);
      end else begin
        cyc(hp);
      end
      sclk = 1'b0;
      if (i == total - 1) cs = 1'b1;
      if ((i % W) == W - 1) begin
        check("master_rx_word", {24'd0, got}, {24'd0, exp_tx});
        model_rx(mo_w[i / W], rdy);
        if (i != total - 1) model_load(exp_tx);
      end
    end
    cyc(4 * hp);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("miso_oe_after_frame", {31'd0, miso_oe}, 32'd0);
    check("miso_after_frame", {31'd0, miso}, 32'd0);
    check("frame_done_count", n_done - d0, (abort_bits == 0) ? 1 : 0);
    check("frame_abort_count", n_abort - a0, (abort_bits != 0) ? 1 : 0);
    check("tx_underrun_count", n_under - u0, exp_under);
    check("rx_overrun_count", n_over - o0, exp_over);
    check("tx_ready_idle", {31'd0, tx_ready}, (buf_q.size() == 0) ? 32'd1 : 32'd0);
    if (held) begin
      check("rx_valid_held", {31'd0, rx_valid}, 32'd1);
      check("rx_data_held", {24'd0, rx_data}, {24'd0, held_word});
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      cyc(1);
      held = 1'b0;
    end
    check("rx_valid_clear", {31'd0, rx_valid}, 32'd0);
    while (got_rd < got_n && exp_q.size() > 0) begin
      check("rx_word", {24'd0, got_arr[got_rd]}, {24'd0, exp_q.pop_front()});
      got_rd++;
    end
    check("rx_word_count", (got_n - got_rd) + exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, {31'd0, miso}, 32'd0);
    check({tag, "_miso_oe"}, {31'd0, miso_oe}, 32'd0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pulses"}, {28'd0, frame_done, frame_abort, tx_underrun, rx_overrun}, 32'd0);
  endtask

  initial begin
    clear_push();
    cyc(3);
    check_reset_vals("por");
    ARESETN = 1'b1;
    cyc(4);

    // Single word with preloaded buffer.
    mo_w[0] = 8'hA5;
    push_tx(8'h3C);
    run_frame(1, 0, 1'b1);

    // Back-to-back words, second tx word pushed during word 1.
    push_tx(8'h81);
    mo_w[0] = 8'h12; mo_w[1] = 8'h34;
    push_en[0] = 1'b1; push_w[0] = 8'h7E;
    run_frame(2, 0, 1'b1);
    clear_push();

    // Underrun on an empty buffer.
    mo_w[0] = 8'h00;
    run_frame(1, 0, 1'b1);

    // Overrun with rx_ready held low.
    mo_w[0] = 8'h55; mo_w[1] = 8'hAA;
    run_frame(2, 0, 1'b0);

    // Abort after 3 rising edges, then a clean frame.
    mo_w[0] = 8'hF0;
    run_frame(1, 3, 1'b1);
    mo_w[0] = 8'hC3;
    run_frame(1, 0, 1'b1);

    // Reset mid-frame with cs held low.
    cs = 1'b0; mosi = 1'b1;
    cyc(hp); sclk = 1'b1; cyc(hp); sclk = 1'b0; cyc(hp); sclk = 1'b1; cyc(2);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    ARESETN = 1'b0;
    cyc(2);
    check_reset_vals("mid_reset");
    ARESETN = 1'b1;
    buf_q.delete();
    repeat (3) begin
      sclk = 1'b0; cyc(hp);
      sclk = 1'b1; cyc(hp);
    end
    sclk = 1'b0;
    cyc(hp);
    check("busy_cs_low_after_reset", {31'd0, busy}, 32'd0);
    check("miso_oe_cs_low_after_reset", {31'd0, miso_oe}, 32'd0);
    check("rx_valid_cs_low_after_reset", {31'd0, rx_valid}, 32'd0);
    cs = 1'b1;
    cyc(2 * hp);
    mo_w[0] = 8'h5A;
    run_frame(1, 0, 1'b1);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      hp = $urandom_range(5, 10);
      for (int k = 0; k < 3; k++) begin
        mo_w[k]    = 8'($urandom_range(0, 255));
        push_w[k]  = 8'($urandom_range(0, 255));
        push_en[k] = 1'($urandom_range(0, 1));
      end
      if (buf_q.size() == 0 && $urandom_range(0, 1) == 1) push_tx(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0)
        run_frame(1, $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      else
        run_frame($urandom_range(1, 3), 0, 1'($urandom_range(0, 1)));
      cyc(hp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
